// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch/data requester and memory bus bundle for mem_port_arbiter
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_stall;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_stall;
  logic [DATA_W-1:0] d_rdata;
  logic              d_valid;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // master: requesters plus the memory array; slave: the arbiter itself
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_stall, if_rdata, if_valid,
    input  d_gnt, d_stall, d_rdata, d_valid,
    input  mem_addr, mem_we, mem_wdata
  );

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_stall, if_rdata, if_valid,
    output d_gnt, d_stall, d_rdata, d_valid,
    output mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port fetch/data memory arbiter with registered read return
// MEM_ARB_STARVE_GUARD_EN enables the fetch starvation counter; undefined gives data strict priority.
module mem_port_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int DATA_BASE  = 128,
  parameter int STARVE_MAX = 3
) (
  input logic                clk,
  input logic                rst,
  mem_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RESP_I, RESP_D} state_t;

  localparam int                CNT_W   = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STARVE_MAX);
  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(DATA_BASE);

  state_t            state_q, state_d;
  logic              if_valid_q, d_valid_q;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              if_gnt, d_gnt, fetch_pri;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  assign fetch_pri = (starve_cnt_q == CNT_MAX);

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!bus.if_req || if_gnt)
      starve_cnt_d = '0;
    else if (d_gnt && (starve_cnt_q != CNT_MAX))
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) starve_cnt_q <= '0;
    else      starve_cnt_q <= starve_cnt_d;
  end
`else
  logic unused_starve_cfg;
  assign unused_starve_cfg = ^CNT_MAX;
  assign fetch_pri         = 1'b0;
`endif

  // Data wins a conflict unless fetch has waited out its starvation budget
  assign d_gnt  = bus.d_req & ~(bus.if_req & fetch_pri);
  assign if_gnt = bus.if_req & ~d_gnt;

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (if_gnt) begin
      mem_addr = bus.if_addr;
    end else if (d_gnt) begin
      mem_addr  = bus.d_addr + BASE;
      mem_we    = bus.d_we;
      mem_wdata = bus.d_wdata;
    end
  end

  always_comb begin
    state_d    = IDLE;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if (if_gnt) begin
      state_d    = RESP_I;
      if_rdata_d = bus.mem_rdata;
    end else if (d_gnt && !bus.d_we) begin
      state_d   = RESP_D;
      d_rdata_d = bus.mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      if_valid_q <= (state_d == RESP_I);
      d_valid_q  <= (state_d == RESP_D);
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign bus.if_gnt    = if_gnt;
  assign bus.if_stall  = bus.if_req & ~if_gnt;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.d_gnt     = d_gnt;
  assign bus.d_stall   = bus.d_req & ~d_gnt;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_valid   = d_valid_q;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_we    = mem_we;
  assign bus.mem_wdata = mem_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  mem_port_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  mem_port_arbiter #(
    .ADDR_W(8), .DATA_W(8), .DATA_BASE(128), .STARVE_MAX(3)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Unwritten words read back as addr ^ 0xA2, so address 0x05 holds 0xA7
  logic [7:0] mem     [256];
  bit         written [256];

  assign bus.mem_rdata = written[bus.mem_addr] ? mem[bus.mem_addr] : (bus.mem_addr ^ 8'hA2);

  always @(posedge clk) begin
    if (bus.mem_we) begin
      mem[bus.mem_addr]     <= bus.mem_wdata;
      written[bus.mem_addr] <= 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) tick();
    checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL reset_if_valid: got %b want 0", bus.if_valid); end
    checks++; if (bus.d_valid !== 1'b0) begin errors++; $display("FAIL reset_d_valid: got %b want 0", bus.d_valid); end
    checks++; if (bus.if_rdata !== 8'h00) begin errors++; $display("FAIL reset_if_rdata: got %h want 00", bus.if_rdata); end
    checks++; if (bus.d_rdata !== 8'h00) begin errors++; $display("FAIL reset_d_rdata: got %h want 00", bus.d_rdata); end
    checks++; if ({bus.if_gnt, bus.d_gnt, bus.mem_we} !== 3'b000) begin errors++; $display("FAIL reset_idle_gnt: got %b want 000", {bus.if_gnt, bus.d_gnt, bus.mem_we}); end
    checks++; if (bus.mem_addr !== 8'h00) begin errors++; $display("FAIL reset_mem_addr: got %h want 00", bus.mem_addr); end
    rst = 1'b1;
    tick();
    checks++; if ({bus.if_valid, bus.d_valid} !== 2'b00) begin errors++; $display("FAIL reset_release_valid: got %b want 00", {bus.if_valid, bus.d_valid}); end
  endtask

  task automatic test_fetch();
    bus.if_req = 1'b1; bus.if_addr = 8'h05;
    #1;
    checks++; if ({bus.if_gnt, bus.if_stall, bus.d_gnt} !== 3'b100) begin errors++; $display("FAIL fetch_gnt: got %b want 100", {bus.if_gnt, bus.if_stall, bus.d_gnt}); end
    checks++; if ({bus.mem_addr, bus.mem_we} !== {8'h05, 1'b0}) begin errors++; $display("FAIL fetch_mem: got %h/%b want 05/0", bus.mem_addr, bus.mem_we); end
    tick();
    bus.if_req = 1'b0;
    checks++; if (bus.if_valid !== 1'b1) begin errors++; $display("FAIL fetch_valid: got %b want 1", bus.if_valid); end
    checks++; if (bus.if_rdata !== 8'hA7) begin errors++; $display("FAIL fetch_rdata: got %h want a7", bus.if_rdata); end
    checks++; if (bus.d_valid !== 1'b0) begin errors++; $display("FAIL fetch_d_idle: got %b want 0", bus.d_valid); end
    tick();
    checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL fetch_valid_one_cycle: got %b want 0", bus.if_valid); end
  endtask

  task automatic test_write_read();
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 8'h10; bus.d_wdata = 8'h3C;
    #1;
    checks++; if ({bus.d_gnt, bus.d_stall} !== 2'b10) begin errors++; $display("FAIL wr_gnt: got %b want 10", {bus.d_gnt, bus.d_stall}); end
    checks++; if ({bus.mem_addr, bus.mem_we, bus.mem_wdata} !== {8'h90, 1'b1, 8'h3C}) begin errors++; $display("FAIL wr_mem: got %h/%b/%h want 90/1/3c", bus.mem_addr, bus.mem_we, bus.mem_wdata); end
    tick();
    checks++; if (bus.d_valid !== 1'b0) begin errors++; $display("FAIL wr_no_valid: got %b want 0", bus.d_valid); end
    bus.d_we = 1'b0; bus.d_wdata = 8'h00;
    #1;
    checks++; if ({bus.mem_addr, bus.mem_we} !== {8'h90, 1'b0}) begin errors++; $display("FAIL rd_mem: got %h/%b want 90/0", bus.mem_addr, bus.mem_we); end
    tick();
    bus.d_req = 1'b0;
    checks++; if ({bus.d_valid, bus.d_rdata} !== {1'b1, 8'h3C}) begin errors++; $display("FAIL raw_rdata: got %b/%h want 1/3c", bus.d_valid, bus.d_rdata); end
    tick();
    checks++; if (bus.d_valid !== 1'b0) begin errors++; $display("FAIL raw_valid_one_cycle: got %b want 0", bus.d_valid); end
  endtask

  task automatic test_wrap();
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 8'h90;
    #1;
    checks++; if (bus.mem_addr !== 8'h10) begin errors++; $display("FAIL wrap_addr: got %h want 10", bus.mem_addr); end
    tick();
    bus.d_req = 1'b0;
    checks++; if ({bus.d_valid, bus.d_rdata} !== {1'b1, 8'hB2}) begin errors++; $display("FAIL wrap_rdata: got %b/%h want 1/b2", bus.d_valid, bus.d_rdata); end
    #1;
    checks++; if ({bus.mem_addr, bus.mem_we, bus.mem_wdata} !== 17'd0) begin errors++; $display("FAIL no_grant_mem: got %h/%b/%h want 00/0/00", bus.mem_addr, bus.mem_we, bus.mem_wdata); end
    tick();
  endtask

  task automatic test_starve();
    bit exp_i;
    bus.if_req = 1'b1; bus.if_addr = 8'h20;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 8'h01;
    for (int k = 0; k < 8; k++) begin
      exp_i = GUARD && (k % 4 == 3);
      #1;
      checks++; if ({bus.if_gnt, bus.d_gnt, bus.if_stall} !== {exp_i, !exp_i, !exp_i}) begin errors++; $display("FAIL starve_gnt[%0d]: got %b want %b", k, {bus.if_gnt, bus.d_gnt, bus.if_stall}, {exp_i, !exp_i, !exp_i}); end
      tick();
      checks++; if ({bus.if_valid, bus.d_valid} !== {exp_i, !exp_i}) begin errors++; $display("FAIL starve_valid[%0d]: got %b want %b", k, {bus.if_valid, bus.d_valid}, {exp_i, !exp_i}); end
      if (exp_i) begin
        checks++; if (bus.if_rdata !== 8'h82) begin errors++; $display("FAIL starve_if_rdata[%0d]: got %h want 82", k, bus.if_rdata); end
      end else begin
        checks++; if (bus.d_rdata !== 8'h23) begin errors++; $display("FAIL starve_d_rdata[%0d]: got %h want 23", k, bus.d_rdata); end
      end
    end
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    bit exp_i;
    bus.if_req = 1'b1; bus.if_addr = 8'h07;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 8'h01;
    repeat (3) tick();
    #1;
    checks++; if (bus.if_gnt !== GUARD) begin errors++; $display("FAIL mid_pre_gnt: got %b want %b", bus.if_gnt, GUARD); end
    rst = 1'b0;
    #1;
    checks++; if ({bus.d_valid, bus.d_rdata, bus.if_rdata} !== 17'd0) begin errors++; $display("FAIL mid_async_clear: got %b/%h/%h want 0/00/00", bus.d_valid, bus.d_rdata, bus.if_rdata); end
    tick();
    checks++; if ({bus.if_valid, bus.if_rdata} !== 9'd0) begin errors++; $display("FAIL mid_held: got %b/%h want 0/00", bus.if_valid, bus.if_rdata); end
    rst = 1'b1;
    checks++; if ({bus.if_valid, bus.d_valid} !== 2'b00) begin errors++; $display("FAIL mid_release_valid: got %b want 00", {bus.if_valid, bus.d_valid}); end
    for (int k = 0; k < 4; k++) begin
      exp_i = GUARD && (k == 3);
      #1;
      checks++; if ({bus.if_gnt, bus.d_gnt} !== {exp_i, !exp_i}) begin errors++; $display("FAIL mid_cnt_cleared[%0d]: got %b want %b", k, {bus.if_gnt, bus.d_gnt}, {exp_i, !exp_i}); end
      tick();
    end
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    tick();
  endtask

  task automatic test_alternate();
    logic [7:0] if_prev;
    if_prev = GUARD ? 8'h2A ^ 8'hA2 : 8'h00;
    bus.if_req = 1'b1; bus.if_addr = 8'h03; bus.d_req = 1'b0;
    #1;
    checks++; if (bus.if_gnt !== 1'b1) begin errors++; $display("FAIL alt_i1_gnt: got %b want 1", bus.if_gnt); end
    tick();
    bus.if_req = 1'b0; bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 8'h05;
    checks++; if ({bus.if_valid, bus.if_rdata, bus.d_valid, bus.d_rdata} !== {1'b1, 8'hA1, 1'b0, 8'h23}) begin errors++; $display("FAIL alt_i1_resp: got %b/%h/%b/%h want 1/a1/0/23", bus.if_valid, bus.if_rdata, bus.d_valid, bus.d_rdata); end
    #1;
    checks++; if (bus.d_gnt !== 1'b1) begin errors++; $display("FAIL alt_d_gnt: got %b want 1", bus.d_gnt); end
    tick();
    bus.d_req = 1'b0; bus.if_req = 1'b1; bus.if_addr = 8'h0C;
    checks++; if ({bus.d_valid, bus.d_rdata, bus.if_valid, bus.if_rdata} !== {1'b1, 8'h27, 1'b0, 8'hA1}) begin errors++; $display("FAIL alt_d_resp: got %b/%h/%b/%h want 1/27/0/a1", bus.d_valid, bus.d_rdata, bus.if_valid, bus.if_rdata); end
    tick();
    bus.if_req = 1'b0;
    checks++; if ({bus.if_valid, bus.if_rdata, bus.d_valid, bus.d_rdata} !== {1'b1, 8'hAE, 1'b0, 8'h27}) begin errors++; $display("FAIL alt_i2_resp: got %b/%h/%b/%h want 1/ae/0/27", bus.if_valid, bus.if_rdata, bus.d_valid, bus.d_rdata); end
    tick();
    checks++; if ({bus.if_valid, bus.d_valid} !== 2'b00) begin errors++; $display("FAIL alt_quiet: got %b want 00", {bus.if_valid, bus.d_valid}); end
    if (if_prev == 8'hFF) $display("note: unreachable prev %h", if_prev);
  endtask

  initial begin
    bus.if_req  = 1'b0;
    bus.if_addr = 8'h00;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = 8'h00;
    bus.d_wdata = 8'h00;
    test_reset();
    test_fetch();
    test_write_read();
    test_wrap();
    test_starve();
    test_reset_mid();
    test_alternate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
